// File: rtl/red_pkg.sv
// Shared sizing, state encoding and nibble helpers for the red_seq reduction unit.
// Defining RED_FAST_EN switches to two nibble pairs per ACCUM cycle (2-cycle latency).
package red_pkg;

  localparam int NIB_W   = 4;
  localparam int NUM_NIB = 4;
  localparam int ACC_W   = 8;
  localparam int RES_W   = 16;
  localparam int OPR_W   = NIB_W * NUM_NIB;
  localparam int SUM_W   = NIB_W + 1;
  localparam int IDX_W   = $clog2(NUM_NIB);

`ifdef RED_FAST_EN
  localparam int LATENCY = 2;
`else
  localparam int LATENCY = 4;
`endif

  localparam int PAIRS_PER_CYC = NUM_NIB / LATENCY;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic [NIB_W-1:0] nib_sel(input logic [OPR_W-1:0] v,
                                               input logic [IDX_W-1:0] i);
    return v[i*NIB_W +: NIB_W];
  endfunction

  function automatic logic [ACC_W-1:0] sext_acc(input logic [SUM_W-1:0] s);
    return {{(ACC_W-SUM_W){s[SUM_W-1]}}, s};
  endfunction

endpackage

// File: rtl/nib_pair_sext_add.sv
// Combinational sum of two signed nibbles, widened by one bit so it never overflows.
// Zero latency, no flow control.
module nib_pair_sext_add
  import red_pkg::*;
(
  input  logic [NIB_W-1:0] a_i,
  input  logic [NIB_W-1:0] b_i,
  output logic [SUM_W-1:0] sum_o
);

  assign sum_o = {a_i[NIB_W-1], a_i} + {b_i[NIB_W-1], b_i};

endmodule

// File: rtl/red_seq.sv
// Iterative signed-nibble reduction of A and B; done pulses LATENCY cycles after start is accepted.
// start is ignored while busy (no queuing); flush aborts and beats start. RED_FAST_EN doubles the step.
module red_seq
  import red_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [OPR_W-1:0] A,
  input  logic [OPR_W-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [RES_W-1:0] Result
);

  state_e             state_q;
  logic [OPR_W-1:0]   a_q;
  logic [OPR_W-1:0]   b_q;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic [RES_W-1:0]   result_q;
  logic [RES_W-1:0]   result_d;
  logic               busy_q;
  logic               done_q;
  logic               accept;
  logic               last_pair;

  logic [NIB_W-1:0]   nib_a0;
  logic [NIB_W-1:0]   nib_b0;
  logic [SUM_W-1:0]   pair0_sum;

  assign nib_a0 = nib_sel(a_q, idx_q);
  assign nib_b0 = nib_sel(b_q, idx_q);

  nib_pair_sext_add u_pair0 (
    .a_i   (nib_a0),
    .b_i   (nib_b0),
    .sum_o (pair0_sum)
  );

`ifdef RED_FAST_EN
  logic [IDX_W-1:0]   idx_1;
  logic [NIB_W-1:0]   nib_a1;
  logic [NIB_W-1:0]   nib_b1;
  logic [SUM_W-1:0]   pair1_sum;

  assign idx_1  = idx_q + IDX_W'(1);
  assign nib_a1 = nib_sel(a_q, idx_1);
  assign nib_b1 = nib_sel(b_q, idx_1);

  nib_pair_sext_add u_pair1 (
    .a_i   (nib_a1),
    .b_i   (nib_b1),
    .sum_o (pair1_sum)
  );

  assign acc_d = acc_q + sext_acc(pair0_sum) + sext_acc(pair1_sum);
`else
  assign acc_d = acc_q + sext_acc(pair0_sum);
`endif

  assign idx_d     = idx_q + IDX_W'(PAIRS_PER_CYC);
  assign last_pair = (idx_q == IDX_W'(NUM_NIB - PAIRS_PER_CYC));
  assign result_d  = {{(RES_W-ACC_W){acc_d[ACC_W-1]}}, acc_d};

  // A new reduction may start from IDLE or straight out of DONE; flush always wins.
  assign accept = start && !flush && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_q     <= A;
        b_q     <= B;
        acc_q   <= '0;
        idx_q   <= '0;
        state_q <= ACCUM;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          ACCUM: begin
            if (flush) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              acc_q <= acc_d;
              idx_q <= idx_d;
              if (last_pair) begin
                result_q <= result_d;
                state_q  <= DONE;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Result = result_q;

endmodule
